// File: rtl/usr_shift_ctrl.sv
// Sequencer for a 4-bit universal shift register: loads a handshaked word, then shifts it out serially.
// Optional rotate mode (in_rot port) is enabled by defining USR_CTRL_ROTATE_EN.
module usr_shift_ctrl #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_dir,
    input  logic             fill_bit,
`ifdef USR_CTRL_ROTATE_EN
    input  logic             in_rot,
`endif
    output logic             S1,
    output logic             S0,
    output logic             MSB_in,
    output logic             LSB_in,
    output logic [WIDTH-1:0] I,
    input  logic [WIDTH-1:0] Q,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] LSB_MASK = WIDTH'(1);
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             dir_q;
    logic             fill_q;
    logic             accept;
    logic             out_bit;
    logic             serial_in;

    assign accept = (state_q == IDLE) && in_valid;

    // Bit leaving the register this cycle: Q[0] for right shifts, Q[WIDTH-1] for left shifts.
    assign out_bit = |(Q & (dir_q ? MSB_MASK : LSB_MASK));

`ifdef USR_CTRL_ROTATE_EN
    logic rot_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rot_q <= 1'b0;
        end else if (accept) begin
            rot_q <= in_rot;
        end
    end

    // Rotation feeds the outgoing bit back into the vacated end.
    assign serial_in = rot_q ? out_bit : fill_q;
`else
    assign serial_in = fill_q;
`endif

    // State, captured word/controls and shift counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            fill_q  <= 1'b0;
            I       <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                I      <= in_data;
                dir_q  <= in_dir;
                fill_q <= fill_bit;
            end
            if (state_q == LOAD) begin
                cnt_q <= '0;
            end else if (state_q == SHIFT) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Next-state and Moore output decode.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        S1        = 1'b0;
        S0        = 1'b0;
        MSB_in    = 1'b0;
        LSB_in    = 1'b0;
        ser_out   = 1'b0;
        ser_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = rst;
                if (in_valid) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                S1      = 1'b1;
                S0      = 1'b1;
                busy    = 1'b1;
                state_d = SHIFT;
            end
            SHIFT: begin
                S1        = dir_q;
                S0        = ~dir_q;
                MSB_in    = ~dir_q & serial_in;
                LSB_in    = dir_q & serial_in;
                ser_out   = out_bit;
                ser_valid = 1'b1;
                busy      = 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_usr_shift_ctrl.sv
// Scoreboard bench for usr_shift_ctrl with a behavioural universal shift register on the Q feedback path.
module tb_usr_shift_ctrl;

    localparam int unsigned WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_dir;
    logic             fill_bit;
`ifdef USR_CTRL_ROTATE_EN
    logic             in_rot;
`endif
    logic             S1;
    logic             S0;
    logic             MSB_in;
    logic             LSB_in;
    logic [WIDTH-1:0] I;
    logic [WIDTH-1:0] Q;
    logic             ser_out;
    logic             ser_valid;
    logic             busy;
    logic             done;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    bit             ser_q[$];
    logic [WIDTH-1:0] fq_q[$];
    int             acc_q[$];

    always #5 clk = ~clk;

    usr_shift_ctrl #(.WIDTH(WIDTH), .CNT_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dir    (in_dir),
        .fill_bit  (fill_bit),
`ifdef USR_CTRL_ROTATE_EN
        .in_rot    (in_rot),
`endif
        .S1        (S1),
        .S0        (S0),
        .MSB_in    (MSB_in),
        .LSB_in    (LSB_in),
        .I         (I),
        .Q         (Q),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .busy      (busy),
        .done      (done)
    );

    // Universal shift register: 00 hold, 01 right (MSB_in enters), 10 left (LSB_in enters), 11 load.
    logic [WIDTH-1:0] q_reg;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_reg <= '0;
        end else begin
            case ({S1, S0})
                2'b01:   q_reg <= {MSB_in, q_reg[WIDTH-1:1]};
                2'b10:   q_reg <= {q_reg[WIDTH-2:0], LSB_in};
                2'b11:   q_reg <= I;
                default: q_reg <= q_reg;
            endcase
        end
    end
    assign Q = q_reg;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept-edge recorder for turnaround measurement.
    always @(posedge clk) begin
        if (rst && in_valid && in_ready) acc_q.push_back(cyc);
        cyc = cyc + 1;
    end

    // Monitor: pops expected serial bits and final register contents.
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        bit               eb;
        logic [WIDTH-1:0] ef;
        if (rst) begin
            if (ser_valid) begin
                if (ser_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL ser_extra: got bit %0d with none expected", ser_out);
                end else begin
                    eb = ser_q.pop_front();
                    check("ser_out", int'(ser_out), int'(eb));
                end
            end
            if (done) begin
                check("done_pulse_prev", int'(prev_done), 0);
                if (fq_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL final_q_extra: got done with Q %0d and none expected", Q);
                end else begin
                    ef = fq_q.pop_front();
                    check("final_q", int'(Q), int'(ef));
                end
            end
            prev_done = done;
        end else begin
            prev_done = 1'b0;
        end
    end

    // seq lists emitted bits in reading order (seq[WIDTH-1] first).
    task automatic send(input logic [WIDTH-1:0] d, input logic dr, input logic f,
                        input logic [WIDTH-1:0] seq, input logic [WIDTH-1:0] fq,
                        input bit hold, input bit push);
        int n;
        n = 0;
        in_data  = d;
        in_dir   = dr;
        fill_bit = f;
        in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: in_ready got 0 expected 1");
            in_valid = 1'b0;
            return;
        end
        if (push) begin
            for (int i = WIDTH - 1; i >= 0; i--) ser_q.push_back(seq[i]);
            fq_q.push_back(fq);
        end
        step();
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 20) begin
            step();
            n++;
        end
        check({name, "_done"}, int'(done), 1);
        step();
        check({name, "_done_low"}, int'(done), 0);
        check({name, "_ready"}, int'(in_ready), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_dir   = 1'b0;
        fill_bit = 1'b0;
`ifdef USR_CTRL_ROTATE_EN
        in_rot   = 1'b0;
`endif
        step();
        step();
        check("rst_mode", int'({S1, S0}), 0);
        check("rst_msb_lsb", int'({MSB_in, LSB_in}), 0);
        check("rst_ser_valid", int'(ser_valid), 0);
        check("rst_busy_done", int'({busy, done}), 0);
        check("rst_I", int'(I), 0);
        rst = 1'b1;
        #1;
        check("rst_ready", int'(in_ready), 1);

        // Right shift 1101, fill 0
        send(4'b1101, 1'b0, 1'b0, 4'b1011, 4'b0000, 1'b0, 1'b1);
        check("r_load_mode", int'({S1, S0}), 3);
        check("r_load_I", int'(I), 13);
        check("r_load_busy", int'(busy), 1);
        check("r_load_ready", int'(in_ready), 0);
        step();
        check("r_shift_mode", int'({S1, S0}), 1);
        check("r_shift_serin", int'({MSB_in, LSB_in}), 0);
        check("r_shift_valid", int'(ser_valid), 1);
        wait_done("right");

        // Left shift 0110, fill 1
        send(4'b0110, 1'b1, 1'b1, 4'b0110, 4'b1111, 1'b0, 1'b1);
        check("l_load_mode", int'({S1, S0}), 3);
        step();
        check("l_shift_mode", int'({S1, S0}), 2);
        check("l_shift_serin", int'({MSB_in, LSB_in}), 1);
        wait_done("left");

        // Back-to-back with in_valid held high
        base = acc_q.size();
        send(4'b1010, 1'b0, 1'b0, 4'b0101, 4'b0000, 1'b1, 1'b1);
        send(4'b0011, 1'b0, 1'b0, 4'b1100, 4'b0000, 1'b0, 1'b1);
        wait_done("b2b");
        check("b2b_accepts", acc_q.size() - base, 2);
        if (acc_q.size() - base == 2) check("b2b_period", acc_q[base+1] - acc_q[base], 7);

        // Offer a different word while busy; it must be ignored
        send(4'b0101, 1'b0, 1'b0, 4'b1010, 4'b0000, 1'b0, 1'b1);
        in_valid = 1'b1;
        in_data  = 4'b1111;
        in_dir   = 1'b1;
        fill_bit = 1'b1;
        check("ign_ready_load", int'(in_ready), 0);
        step();
        check("ign_ready_shift", int'(in_ready), 0);
        check("ign_I", int'(I), 5);
        check("ign_mode", int'({S1, S0}), 1);
        check("ign_serin", int'({MSB_in, LSB_in}), 0);
        step();
        in_valid = 1'b0;
        wait_done("ignore");

        // Reset during the second SHIFT cycle
        send(4'b1101, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
        ser_q.push_back(1'b1);
        step();
        step();
        rst = 1'b0;
        #1;
        check("mid_rst_mode", int'({S1, S0}), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_valid", int'(ser_valid), 0);
        check("mid_rst_done", int'(done), 0);
        check("mid_rst_I", int'(I), 0);
        step();
        rst = 1'b1;
        #1;
        check("mid_rst_ready", int'(in_ready), 1);

`ifdef USR_CTRL_ROTATE_EN
        // Rotate right: the word comes back intact
        in_rot = 1'b1;
        send(4'b1001, 1'b0, 1'b0, 4'b1001, 4'b1001, 1'b0, 1'b1);
        wait_done("rotate");
        in_rot = 1'b0;
`endif

        step();
        check("ser_q_empty", ser_q.size(), 0);
        check("fq_q_empty", fq_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/usr_shift_ctrl.md
Name: usr_shift_ctrl

Overview:
- Upstream sequencer for the 4-bit universal shift register. It converts a parallel word, offered with a valid/ready handshake, into a parallel-load operation followed by exactly WIDTH serial shifts.
- Drives the register's S1/S0/MSB_in/LSB_in/I inputs and takes Q back so it can present the serial output stream with a valid strobe.
- Sits between the word source and the shift register; the register's mode encoding is fixed as 00 hold, 01 shift right (MSB_in enters), 10 shift left (LSB_in enters), 11 parallel load.

Parameters:
- WIDTH, 4, register width; must match the shift register instance.
- CNT_W, 3, shift counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- in_valid  input  1  source offers in_data/in_dir/fill_bit.
- in_ready  output  1  controller can accept a word.
- in_data  input  WIDTH  word to serialise.
- in_dir  input  1  0 = shift right (LSB first), 1 = shift left (MSB first).
- fill_bit  input  1  bit shifted into the vacated end.
- S1, S0  output  1 each  mode select to the shift register.
- MSB_in  output  1  serial-in for right shift.
- LSB_in  output  1  serial-in for left shift.
- I  output  WIDTH  parallel-load data to the shift register.
- Q  input  WIDTH  shift register state (feedback).
- ser_out  output  1  outgoing serial bit.
- ser_valid  output  1  ser_out is valid this cycle.
- busy  output  1  transfer in progress.
- done  output  1  one-cycle pulse when a transfer completes.

Behaviour:
- FSM states and transitions:
  - IDLE: on in_valid, capture the word, go to LOAD.
  - LOAD: after one cycle, go to SHIFT.
  - SHIFT: stay WIDTH cycles, then go to DONE.
  - DONE: after one cycle, return to IDLE.
- Handshake:
  - in_ready = 1 only in IDLE. A transfer occurs on a rising edge with in_valid & in_ready.
  - in_data is captured into the I register; in_dir and fill_bit are captured into internal registers.
  - in_valid in any other state is ignored; captured values do not change.
- Mode outputs (Moore, decoded from the state):
  - IDLE/DONE: S1S0 = 00.
  - LOAD: S1S0 = 11.
  - SHIFT: S1S0 = 01 if dir = 0, 10 if dir = 1.
- Serial inputs:
  - MSB_in = fill when in SHIFT with dir = 0, else 0.
  - LSB_in = fill when in SHIFT with dir = 1, else 0.
- Serial output:
  - In SHIFT: ser_valid = 1; ser_out = Q[0] if dir = 0, Q[WIDTH-1] if dir = 1. The register shifts at the end of the cycle.
  - Outside SHIFT: ser_valid = 0, ser_out = 0.
- Counter:
  - Cleared on entry to SHIFT; increments each SHIFT cycle.
  - Leaves SHIFT when count == WIDTH-1. Exactly WIDTH bits are emitted.
- busy = 1 in LOAD, SHIFT and DONE. done = 1 only in DONE.
- Latency:
  - First ser_valid is 2 cycles after the accepting edge.
  - Accept-to-accept minimum period is WIDTH+3 cycles (7 for WIDTH = 4).
- Reset (rst = 0, any time, including mid-shift):
  - State goes to IDLE; counter, dir and fill go to 0; I = 0.
  - Outputs: S1S0 = 00, MSB_in = LSB_in = 0, ser_valid = 0, done = 0, busy = 0.
  - in_ready = 1 once rst = 1.
- On the first edge after reset release, a word may be accepted if in_valid = 1.

Optional Feature:
- USR_CTRL_ROTATE_EN:
  - When defined, adds input in_rot (1 bit), captured with the word.
  - If rot = 1, the serial-in is the outgoing bit instead of fill: MSB_in = Q[0] for a right shift, LSB_in = Q[WIDTH-1] for a left shift. After WIDTH shifts the register holds the original word.
  - When not defined, the in_rot port is absent and fill_bit is always used.

Test Plan:
- Reset mid-transfer: assert rst = 0 during the 2nd SHIFT cycle -> same cycle S1S0 = 00, busy = 0, ser_valid = 0, done = 0; in_ready = 1 after release.
- Right shift: in_data = 1101, in_dir = 0, fill_bit = 0 -> LOAD with S1S0 = 11, I = 1101; 4 SHIFT cycles with S1S0 = 01, ser_out 1,0,1,1; Q = 0000 after last shift; done high for one cycle; 7-cycle turnaround.
- Left shift: in_data = 0110, in_dir = 1, fill_bit = 1 -> S1S0 = 10, LSB_in = 1, ser_out 0,1,1,0; final Q = 1111.
- Back-to-back: in_valid held high with words 1010 then 0011 -> second accept exactly 7 cycles after the first; ser stream 0,1,0,1 then 1,1,0,0.
- Busy ignore: in_valid = 1 with in_data = 1111 during SHIFT -> in_ready = 0, I unchanged, emitted bits unaffected.
- With USR_CTRL_ROTATE_EN defined: in_data = 1001, in_dir = 0, in_rot = 1 -> ser_out 1,0,0,1; Q = 1001 at DONE.
